// File: rtl/tlul_host_seq.sv
// TL-UL host sequencer: runs a table of WRITE/READ/POLL commands
// one transaction at a time and reports pass/fail with error code.
package tlul_pkg;
  localparam logic [2:0] PutFullData = 3'h0;
  localparam logic [2:0] Get = 3'h4;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    instr_type: 4'h9,
    cmd_intg: 7'h0,
    data_intg: 7'h0
  };

  typedef struct packed {
    logic a_valid;
    logic [2:0] a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [31:0] a_address;
    logic [3:0] a_mask;
    logic [31:0] a_data;
    tl_a_user_t a_user;
    logic d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic d_valid;
    logic [2:0] d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic d_error;
    logic a_ready;
  } tl_d2h_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '{
    a_valid: 1'b0,
    a_opcode: 3'h0,
    a_param: 3'h0,
    a_size: 2'h0,
    a_source: 8'h0,
    a_address: 32'h0,
    a_mask: 4'h0,
    a_data: 32'h0,
    a_user: TL_A_USER_DEFAULT,
    d_ready: 1'b0
  };
endpackage

module tlul_host_seq
  import tlul_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned PollMax = 256,
  localparam int unsigned IW = $clog2(Depth),
  localparam int unsigned NW = $clog2(Depth + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cmd_we_i,
  input  logic [IW-1:0] cmd_idx_i,
  input  logic [1:0] cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic [31:0] cmd_mask_i,
  input  logic start_i,
  input  logic [NW-1:0] num_cmds_i,
  input  logic abort_i,
  output tl_h2d_t tl_o,
  input  tl_d2h_t tl_i,
  output logic busy_o,
  output logic done_o,
  output logic pass_o,
  output logic [1:0] err_code_o,
  output logic [IW-1:0] err_idx_o,
  output logic [31:0] rdata_o
);
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);
  localparam int unsigned PW = $clog2(PollMax + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_POLL = 2'd2;

  localparam logic [1:0] E_DERR = 2'd1;
  localparam logic [1:0] E_CMP = 2'd2;
  localparam logic [1:0] E_TMO = 2'd3;

  logic [1:0] t_op [Depth];
  logic [31:0] t_addr [Depth];
  logic [31:0] t_data [Depth];
  logic [31:0] t_mask [Depth];

  logic [1:0] state;
  logic [NW-1:0] ptr, ncmds, n_clamp;
  logic [TW-1:0] to_cnt;
  logic [PW-1:0] poll_cnt;
  logic abort_q;

  logic [IW-1:0] slot;
  logic [1:0] cur_op;
  logic [31:0] cur_addr, cur_data, cur_mask;
  logic is_get, cmp_ok, to_hit, poll_last, last;

  always_ff @(posedge clk_i) begin
    if (state == IDLE && cmd_we_i && 32'(cmd_idx_i) < Depth) begin
      t_op[cmd_idx_i] <= cmd_op_i;
      t_addr[cmd_idx_i] <= cmd_addr_i;
      t_data[cmd_idx_i] <= cmd_data_i;
      t_mask[cmd_idx_i] <= cmd_mask_i;
    end
  end

  assign slot = ptr[IW-1:0];
  assign cur_op = t_op[slot];
  assign cur_addr = t_addr[slot];
  assign cur_data = t_data[slot];
  assign cur_mask = t_mask[slot];
  assign is_get = (cur_op == OP_READ) || (cur_op == OP_POLL);
  assign cmp_ok = ((tl_i.d_data ^ cur_data) & cur_mask) == 32'h0;
  assign to_hit = to_cnt == TW'(TimeoutCycles);
  assign poll_last = poll_cnt == PW'(PollMax);
  assign last = (ptr + NW'(1)) == ncmds;
  assign n_clamp = (32'(num_cmds_i) > Depth) ? NW'(Depth) : num_cmds_i;

  // Request is a pure function of state and the current slot, so it
  // stays stable until the handshake and drops as soon as reset hits.
  always_comb begin
    tl_o = TL_H2D_DEFAULT;
    tl_o.d_ready = state == WAIT;
    if (state == ISSUE) begin
      tl_o.a_valid = 1'b1;
      tl_o.a_opcode = is_get ? Get : PutFullData;
      tl_o.a_size = 2'd2;
      tl_o.a_mask = 4'hf;
      tl_o.a_address = cur_addr;
      tl_o.a_data = is_get ? 32'h0 : cur_data;
    end
  end

  assign busy_o = state != IDLE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      ncmds <= '0;
      to_cnt <= '0;
      poll_cnt <= '0;
      abort_q <= 1'b0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
      err_code_o <= 2'd0;
      err_idx_o <= '0;
      rdata_o <= 32'h0;
    end else begin
      if ((state == ISSUE || state == WAIT) && !to_hit) to_cnt <= to_cnt + TW'(1);
      if ((state == ISSUE || state == WAIT) && abort_i) abort_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            err_code_o <= 2'd0;
            err_idx_o <= '0;
            if (num_cmds_i == '0) begin
              done_o <= 1'b1;
              pass_o <= 1'b1;
            end else begin
              done_o <= 1'b0;
              pass_o <= 1'b0;
              ptr <= '0;
              ncmds <= n_clamp;
              to_cnt <= '0;
              poll_cnt <= '0;
              abort_q <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (tl_i.a_ready) begin
            state <= WAIT;
            if (to_hit) begin
              err_code_o <= E_TMO;
              err_idx_o <= slot;
            end
          end
        end
        WAIT: begin
          if (tl_i.d_valid) begin
            rdata_o <= tl_i.d_data;
            if (to_hit || tl_i.d_error ||
                (cur_op == OP_READ && !cmp_ok) ||
                (cur_op == OP_POLL && !cmp_ok && poll_last)) begin
              err_code_o <= to_hit ? E_TMO : (tl_i.d_error ? E_DERR : E_CMP);
              err_idx_o <= slot;
              done_o <= 1'b1;
              pass_o <= 1'b0;
              state <= FINISH;
            end else if (abort_q || abort_i) begin
              done_o <= 1'b1;
              pass_o <= 1'b0;
              state <= FINISH;
            end else if (cur_op == OP_POLL && !cmp_ok) begin
              poll_cnt <= poll_cnt + PW'(1);
              state <= ISSUE;
            end else if (last) begin
              ptr <= ptr + NW'(1);
              done_o <= 1'b1;
              pass_o <= 1'b1;
              state <= FINISH;
            end else begin
              ptr <= ptr + NW'(1);
              to_cnt <= '0;
              poll_cnt <= '0;
              state <= ISSUE;
            end
          end
        end
        FINISH: state <= IDLE;
      endcase
    end
  end

  logic unused_d;
  assign unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                      tl_i.d_source, tl_i.d_sink, tl_i.d_user};
endmodule

// File: tb/tb_tlul_host_seq.sv
// Bench for tlul_host_seq: vector table of single-command runs plus
// directed multi-command sequences against a small TL-UL device model.
module tb_tlul_host_seq;
  import tlul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we = 1'b0;
  logic [3:0] idx = '0;
  logic [1:0] op = '0;
  logic [31:0] addr = '0, data = '0, mask = '0;
  logic start = 1'b0;
  logic [4:0] num = '0;
  logic abort = 1'b0;
  tl_h2d_t tl_o;
  tl_d2h_t dev;
  logic busy, done, pass;
  logic [1:0] err;
  logic [3:0] eidx;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rsp_d [512];
  logic rsp_e [512];
  int rsp_i = 0;
  int rsp_delay = 0;
  int due_cnt = 0;
  int stall = 0;
  int proto_err = 0;
  int n_log = 0;
  logic [2:0] log_op [512];
  logic [31:0] log_addr [512];
  logic [31:0] log_data [512];
  logic log_fix [512];

  typedef struct {
    logic [1:0] op;
    logic [31:0] addr, data, mask, rd;
    logic re;
    logic [2:0] opc;
    logic [31:0] ad;
    logic [1:0] err;
    logic pass;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  tlul_host_seq #(.Depth(16), .TimeoutCycles(1024), .PollMax(256)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_we_i(we), .cmd_idx_i(idx), .cmd_op_i(op),
    .cmd_addr_i(addr), .cmd_data_i(data), .cmd_mask_i(mask),
    .start_i(start), .num_cmds_i(num), .abort_i(abort),
    .tl_o(tl_o), .tl_i(dev),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_code_o(err), .err_idx_o(eidx), .rdata_o(rdata)
  );

  // Device: accepts when not stalled, answers rsp_delay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      dev.d_valid = 1'b0;
      if (due_cnt == 1) begin
        if (!tl_o.d_ready) proto_err++;
        dev.d_valid = 1'b1;
        dev.d_data = rsp_d[rsp_i % 512];
        dev.d_error = rsp_e[rsp_i % 512];
        rsp_i++;
      end
      if (due_cnt > 0) due_cnt--;
      if (stall > 0) begin
        stall--;
        dev.a_ready = 1'b0;
      end else begin
        dev.a_ready = 1'b1;
      end
      if (tl_o.a_valid && dev.a_ready) begin
        if (due_cnt > 0 || dev.d_valid) proto_err++;
        if (n_log < 512) begin
          log_op[n_log] = tl_o.a_opcode;
          log_addr[n_log] = tl_o.a_address;
          log_data[n_log] = tl_o.a_data;
          log_fix[n_log] = tl_o.a_size == 2'd2 && tl_o.a_mask == 4'hf &&
                           tl_o.a_source == 8'h0 && tl_o.a_param == 3'h0 &&
                           tl_o.a_user == TL_A_USER_DEFAULT;
        end
        n_log++;
        due_cnt = rsp_delay + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic dev_clear();
    for (int i = 0; i < 512; i++) begin
      rsp_d[i] = 32'h0;
      rsp_e[i] = 1'b0;
    end
    rsp_i = 0;
    n_log = 0;
    rsp_delay = 0;
    stall = 0;
  endtask

  task automatic load(input int i, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] m);
    @(negedge clk);
    we = 1'b1;
    idx = 4'(i);
    op = o;
    addr = a;
    data = d;
    mask = m;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic go(input int n);
    @(negedge clk);
    start = 1'b1;
    num = 5'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 6000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk({nm, " done"}, done, 1'b1);
    @(negedge clk);
    chk({nm, " idle"}, busy, 1'b0);
  endtask

  initial begin
    vt[0] = '{2'd0, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 3'h0, 32'hDEADBEEF, 2'd0, 1'b1};
    vt[1] = '{2'd3, 32'h104, 32'h12345678, 32'hFFFFFFFF, 32'h55, 1'b0, 3'h0, 32'h12345678, 2'd0, 1'b1};
    vt[2] = '{2'd1, 32'h108, 32'hA5, 32'hFF, 32'h123456A5, 1'b0, 3'h4, 32'h0, 2'd0, 1'b1};
    vt[3] = '{2'd1, 32'h10C, 32'hA5, 32'hFF, 32'hA4, 1'b0, 3'h4, 32'h0, 2'd2, 1'b0};
    vt[4] = '{2'd1, 32'h110, 32'hFFFF, 32'h0, 32'h0, 1'b0, 3'h4, 32'h0, 2'd0, 1'b1};
    vt[5] = '{2'd0, 32'h114, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 3'h0, 32'h1, 2'd1, 1'b0};
    vt[6] = '{2'd1, 32'h118, 32'h7, 32'hF, 32'h7, 1'b1, 3'h4, 32'h0, 2'd1, 1'b0};
    vt[7] = '{2'd2, 32'h11C, 32'h80, 32'h80, 32'hFF, 1'b0, 3'h4, 32'h0, 2'd0, 1'b1};

    dev = '0;
    dev.a_ready = 1'b1;
    dev_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst tl_o", tl_o, TL_H2D_DEFAULT);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst pass", pass, 1'b0);
    chk("rst err", err, 2'd0);
    chk("rst eidx", eidx, 4'd0);
    chk("rst rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // num_cmds == 0 finishes without issuing anything
    go(0);
    chk("zero done", done, 1'b1);
    chk("zero pass", pass, 1'b1);
    chk("zero busy", busy, 1'b0);
    chk("zero nlog", n_log, 0);

    for (int v = 0; v < 8; v++) begin
      dev_clear();
      rsp_d[0] = vt[v].rd;
      rsp_e[0] = vt[v].re;
      load(0, vt[v].op, vt[v].addr, vt[v].data, vt[v].mask);
      go(1);
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d nlog", v), n_log, 1);
      chk($sformatf("vec%0d opc", v), log_op[0], vt[v].opc);
      chk($sformatf("vec%0d addr", v), log_addr[0], vt[v].addr);
      chk($sformatf("vec%0d adata", v), log_data[0], vt[v].ad);
      chk($sformatf("vec%0d fixed", v), log_fix[0], 1'b1);
      chk($sformatf("vec%0d err", v), err, vt[v].err);
      chk($sformatf("vec%0d pass", v), pass, vt[v].pass);
      chk($sformatf("vec%0d rdata", v), rdata, vt[v].rd);
    end

    // two writes then a read-back; table writes while busy are ignored
    dev_clear();
    rsp_d[2] = 32'h4;
    load(0, 2'd0, 32'h10, 32'h4, 32'h0);
    load(1, 2'd0, 32'h14, 32'h1, 32'h0);
    load(2, 2'd1, 32'h10, 32'h4, 32'hF);
    go(3);
    @(negedge clk);
    we = 1'b1;
    idx = 4'd2;
    addr = 32'h99;
    @(negedge clk);
    we = 1'b0;
    wait_done("seq3");
    chk("seq3 nlog", n_log, 3);
    chk("seq3 a0", log_addr[0], 32'h10);
    chk("seq3 d0", log_data[0], 32'h4);
    chk("seq3 a1", log_addr[1], 32'h14);
    chk("seq3 d1", log_data[1], 32'h1);
    chk("seq3 a2", log_addr[2], 32'h10);
    chk("seq3 op2", log_op[2], 3'h4);
    chk("seq3 pass", pass, 1'b1);
    chk("seq3 rdata", rdata, 32'h4);

    // poll succeeds on third try
    dev_clear();
    rsp_d[2] = 32'h1;
    load(0, 2'd2, 32'h0C, 32'h1, 32'h1);
    go(1);
    wait_done("poll");
    chk("poll nlog", n_log, 3);
    chk("poll op1", log_op[1], 3'h4);
    chk("poll addr2", log_addr[2], 32'h0C);
    chk("poll pass", pass, 1'b1);

    // poll never matches: initial Get plus 256 reissues
    dev_clear();
    load(0, 2'd2, 32'h0C, 32'h1, 32'h1);
    go(1);
    wait_done("pollmax");
    chk("pollmax nlog", n_log, 257);
    chk("pollmax err", err, 2'd2);
    chk("pollmax pass", pass, 1'b0);

    // read mismatch stops the sequence
    dev_clear();
    load(0, 2'd1, 32'h20, 32'hFFFFFFFF, 32'hFFFFFFFF);
    load(1, 2'd0, 32'h24, 32'h0, 32'h0);
    go(2);
    wait_done("rdmis");
    repeat (10) @(negedge clk);
    chk("rdmis nlog", n_log, 1);
    chk("rdmis err", err, 2'd2);
    chk("rdmis eidx", eidx, 4'd0);
    chk("rdmis pass", pass, 1'b0);
    chk("rdmis avalid", tl_o.a_valid, 1'b0);

    // d_error on slot 1 of 3
    dev_clear();
    rsp_e[1] = 1'b1;
    load(0, 2'd0, 32'h30, 32'h1, 32'h0);
    load(1, 2'd0, 32'h34, 32'h2, 32'h0);
    load(2, 2'd0, 32'h38, 32'h3, 32'h0);
    go(3);
    wait_done("derr");
    chk("derr nlog", n_log, 2);
    chk("derr err", err, 2'd1);
    chk("derr eidx", eidx, 4'd1);
    chk("derr pass", pass, 1'b0);

    // device stalls a_ready past the timeout
    dev_clear();
    stall = 2000;
    load(0, 2'd0, 32'h40, 32'h5, 32'h0);
    go(1);
    repeat (1500) @(negedge clk);
    chk("tmo held", tl_o.a_valid, 1'b1);
    chk("tmo haddr", tl_o.a_address, 32'h40);
    chk("tmo hdone", done, 1'b0);
    wait_done("tmo");
    chk("tmo nlog", n_log, 1);
    chk("tmo err", err, 2'd3);
    chk("tmo pass", pass, 1'b0);

    // abort during the first response wait of four
    dev_clear();
    rsp_delay = 5;
    for (int i = 0; i < 4; i++) load(i, 2'd0, 32'h50 + 32'(4 * i), 32'(i), 32'h0);
    go(4);
    for (int i = 0; i < 50; i++) begin
      if (n_log >= 1) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("abort inwait", tl_o.d_ready, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort");
    chk("abort nlog", n_log, 1);
    chk("abort rsp", rsp_i, 1);
    chk("abort pass", pass, 1'b0);
    chk("abort err", err, 2'd0);

    // num_cmds above Depth clamps to Depth
    dev_clear();
    for (int i = 0; i < 16; i++) load(i, 2'd0, 32'h200 + 32'(4 * i), 32'(i), 32'h0);
    go(20);
    wait_done("clamp");
    chk("clamp nlog", n_log, 16);
    chk("clamp last", log_addr[15], 32'h23C);
    chk("clamp pass", pass, 1'b1);

    // reset mid-transaction drops a_valid at once
    dev_clear();
    stall = 100;
    load(0, 2'd0, 32'h60, 32'h6, 32'h0);
    go(1);
    repeat (3) @(negedge clk);
    chk("mrst pre", tl_o.a_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst avalid", tl_o.a_valid, 1'b0);
    chk("mrst busy", busy, 1'b0);
    chk("mrst done", done, 1'b0);
    dev_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("proto", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
